// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the icache/dcache memory scheduler.
package mem_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY,
    ST_RESP
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam int          LINE_BYTES = 64;
  localparam logic [63:0] OFF_MASK   = 64'(LINE_BYTES - 1);

  // Clear the in-line byte offset of an address.
  function automatic logic [63:0] line_align(input logic [63:0] addr);
    return addr & ~OFF_MASK;
  endfunction

endpackage

// File: rtl/mem_sched_age.sv
// Winner selection between icache and dcache, with optional I-starvation aging.
// Aging is compiled in only when MEM_SCHED_AGING_EN is defined.
module mem_sched_age
  import mem_sched_pkg::*;
#(
  parameter int AGE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic in_idle,
  input  logic grant,
  output logic sel_i
);

`ifdef MEM_SCHED_AGING_EN
  logic [3:0] r_age;
  logic       w_aged;

  assign w_aged = (r_age == 4'(AGE_LIMIT));
  assign sel_i  = i_req & (~d_req | w_aged);

  // Counts D grants that overtook a waiting I; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset)
      r_age <= '0;
    else if (grant && sel_i)
      r_age <= '0;
    else if (in_idle && !i_req)
      r_age <= '0;
    else if (grant && i_req && !w_aged)
      r_age <= r_age + 4'd1;
  end
`else
  logic w_unused;

  assign sel_i    = i_req & ~d_req;
  assign w_unused = &{1'b0, clk, reset, in_idle, grant};
`endif

endmodule

// File: rtl/mem_sched.sv
// Single-engine line-transfer scheduler arbitrating icache fills against dcache fills/writebacks.
// Define MEM_SCHED_AGING_EN to let a starved icache request overtake the dcache.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int LINE_W    = 512,
  parameter int AGE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_done,
  output logic              eng_start,
  output logic              eng_wr,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [LINE_W-1:0] eng_wdata,
  input  logic [LINE_W-1:0] eng_rdata,
  input  logic              eng_done,
  output logic              sched_err
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(OFF_MASK);

  state_t            r_state, w_next;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_irdata, r_drdata;
  logic              r_err;
  logic              w_idle, w_any, w_grant, w_sel_i;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_any   = i_req | d_req;
  assign w_grant = w_idle & w_any;

  mem_sched_age #(.AGE_LIMIT(AGE_LIMIT)) u_age (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .d_req   (d_req),
    .in_idle (w_idle),
    .grant   (w_grant),
    .sel_i   (w_sel_i)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_BUSY;
      ST_BUSY:  if (eng_done) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Transfer descriptor is captured once at grant and held until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN_I;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_owner <= w_sel_i ? OWN_I : OWN_D;
      r_addr  <= (w_sel_i ? i_addr : d_addr) & ADDR_MASK;
      r_wr    <= ~w_sel_i & d_wr;
      r_wdata <= w_sel_i ? '0 : d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irdata <= '0;
      r_drdata <= '0;
      r_err    <= 1'b0;
    end else begin
      if (eng_done && r_state == ST_BUSY) begin
        if (r_owner == OWN_I) r_irdata <= eng_rdata;
        else                  r_drdata <= eng_rdata;
      end
      // A completion we are not waiting for is a protocol violation; it latches.
      if (eng_done && r_state != ST_BUSY)
        r_err <= 1'b1;
    end
  end

  assign eng_start = (r_state == ST_ISSUE);
  assign eng_wr    = r_wr;
  assign eng_addr  = r_addr;
  assign eng_wdata = r_wdata;
  assign i_done    = (r_state == ST_RESP) && (r_owner == OWN_I);
  assign d_done    = (r_state == ST_RESP) && (r_owner == OWN_D);
  assign i_rdata   = r_irdata;
  assign d_rdata   = r_drdata;
  assign sched_err = r_err;

endmodule

// File: tb/tb_mem_sched.sv
// Directed bench for mem_sched: reset, latency, arbitration/aging, abort and stray-done cases.
module tb_mem_sched;
  import mem_sched_pkg::*;

  localparam int ADDR_W = 64;
  localparam int LINE_W = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req, d_req, d_wr;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, i_rdata, d_rdata;
  logic              i_done, d_done;
  logic              eng_start, eng_wr, eng_done, sched_err;
  logic [ADDR_W-1:0] eng_addr;
  logic [LINE_W-1:0] eng_wdata, eng_rdata;

  logic              m_done = 1'b0, stray_done = 1'b0, eng_auto = 1'b1;
  int                eng_lat = 1, ecnt = 0;
  logic [LINE_W-1:0] rpat = '0;

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, n_idone = 0, n_ddone = 0;
  logic done_log[$];
  int   start_cyc[$];
  logic start_wr[$];

  assign eng_done  = m_done | stray_done;
  assign eng_rdata = rpat;

  always #5 clk = ~clk;

  mem_sched #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .AGE_LIMIT(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .eng_start(eng_start), .eng_wr(eng_wr), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_rdata(eng_rdata), .eng_done(eng_done),
    .sched_err(sched_err)
  );

  // Engine model: completes eng_lat cycles after the start cycle.
  always @(negedge clk) begin
    m_done = 1'b0;
    if (eng_start && eng_auto) ecnt = eng_lat;
    else if (ecnt > 0) begin
      ecnt--;
      if (ecnt == 0) m_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (i_done) begin done_log.push_back(1'b0); n_idone++; end
    if (d_done) begin done_log.push_back(1'b1); n_ddone++; end
    if (eng_start) begin start_cyc.push_back(cyc); start_wr.push_back(eng_wr); end
  end

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clr_logs();
    done_log.delete(); start_cyc.delete(); start_wr.delete();
    n_idone = 0; n_ddone = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int                start_k, done_k;
    logic [ADDR_W-1:0] a_cap;
    logic              w_cap;
    logic [LINE_W-1:0] wd_cap, exp_i;
    logic [LINE_W-1:0] p1, p2, p3, pa5, wpat;
    logic              exp_ord [6];

    p1   = {16{32'hCAFE_0042}};
    p2   = {16{32'h0BAD_F00D}};
    p3   = {16{32'h1234_5678}};
    pa5  = {64{8'hA5}};
    wpat = {8{64'hDEAD_BEEF_0000_0043}};

    reset = 1'b1; i_req = 0; d_req = 0; d_wr = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    tick(3);
    chk("rst_state", 512'(dut.r_state), 512'(ST_IDLE));
    chk("rst_eng_start", 512'(eng_start), 512'(0));
    chk("rst_i_done", 512'(i_done), 512'(0));
    chk("rst_d_done", 512'(d_done), 512'(0));
    chk("rst_sched_err", 512'(sched_err), 512'(0));
    chk("rst_eng_wr", 512'(eng_wr), 512'(0));
    chk("rst_eng_addr", 512'(eng_addr), 512'(0));
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    reset = 1'b0;
    tick(1);

    // Lone icache fill, engine done 5 cycles after start.
    clr_logs(); eng_lat = 5; rpat = p1;
    i_req = 1; i_addr = 64'h1047;
    start_k = -1; done_k = -1; a_cap = '0; w_cap = 1'bx;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      if (eng_start && start_k < 0) begin start_k = k; a_cap = eng_addr; w_cap = eng_wr; end
      if (i_done && done_k < 0) begin done_k = k; i_req = 0; end
    end
    chk("lone_start_cycle", 512'(start_k), 512'(1));
    chk("lone_eng_addr", 512'(a_cap), 512'(64'h1040));
    chk("lone_eng_wr", 512'(w_cap), 512'(0));
    chk("lone_i_done_in_8th_cycle", 512'(done_k + 1), 512'(8));
    chk("lone_i_done_count", 512'(n_idone), 512'(1));
    chk("lone_d_done_count", 512'(n_ddone), 512'(0));
    chk("lone_i_rdata", i_rdata, p1);

    // Simultaneous D writeback and I fill: D first.
    clr_logs(); eng_lat = 3; rpat = p2;
    d_req = 1; d_wr = 1; d_addr = 64'h20BF; d_wdata = wpat;
    i_req = 1; i_addr = 64'h3000;
    start_k = -1; a_cap = '0; wd_cap = '0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (eng_start && start_k < 0) begin start_k = k; a_cap = eng_addr; wd_cap = eng_wdata; end
      if (d_done) d_req = 0;
      if (i_done) i_req = 0;
    end
    d_wr = 0;
    chk("both_done_order_len", 512'(done_log.size()), 512'(2));
    chk("both_first_is_d", 512'((done_log.size() > 0) ? done_log[0] : 1'bx), 512'(1));
    chk("both_second_is_i", 512'((done_log.size() > 1) ? done_log[1] : 1'bx), 512'(0));
    chk("both_first_eng_wr", 512'((start_wr.size() > 0) ? start_wr[0] : 1'bx), 512'(1));
    chk("both_second_eng_wr", 512'((start_wr.size() > 1) ? start_wr[1] : 1'bx), 512'(0));
    chk("both_wb_addr", 512'(a_cap), 512'(64'h2080));
    chk("both_wb_wdata", wd_cap, wpat);
    chk("both_d_done_count", 512'(n_ddone), 512'(1));
    chk("both_i_done_count", 512'(n_idone), 512'(1));
    exp_i = p2;

    // Both requests held continuously, engine latency 1 (minimum start spacing).
    clr_logs(); eng_lat = 1; rpat = p3;
    d_req = 1; d_wr = 0; d_addr = 64'h5000; i_req = 1; i_addr = 64'h6000;
`ifdef MEM_SCHED_AGING_EN
    exp_ord = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 200 && done_log.size() < 6; k++) tick(1);
    for (int k = 0; k < 6; k++)
      chk($sformatf("aging_order_%0d", k),
          512'((k < done_log.size()) ? done_log[k] : 1'bx), 512'(exp_ord[k]));
    exp_i = p3;
`else
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 300 && n_ddone < 20; k++) tick(1);
    chk("strict_d_done_count", 512'(n_ddone), 512'(20));
    chk("strict_i_never_done", 512'(n_idone), 512'(0));
    for (int k = 0; k < 3; k++)
      chk($sformatf("strict_order_%0d", k),
          512'((k < done_log.size()) ? done_log[k] : 1'bx), 512'(exp_ord[k]));
`endif
    chk("start_gap_min", 512'((start_cyc.size() > 1) ? start_cyc[1] - start_cyc[0] : -1), 512'(4));
    d_req = 0; i_req = 0;
    tick(8);

    // dcache drops its request mid-transfer; completion still delivered.
    clr_logs(); eng_lat = 4; rpat = pa5;
    d_req = 1; d_wr = 0; d_addr = 64'h40;
    tick(3);
    chk("drop_in_busy", 512'(dut.r_state), 512'(ST_BUSY));
    d_req = 0;
    for (int k = 0; k < 20 && n_ddone == 0; k++) tick(1);
    tick(2);
    chk("drop_d_done_count", 512'(n_ddone), 512'(1));
    chk("drop_d_rdata", d_rdata, pa5);
    chk("hold_i_rdata", i_rdata, exp_i);

    // Reset during BUSY, then a stray engine completion.
    clr_logs(); eng_auto = 0;
    d_req = 1; d_addr = 64'h80;
    tick(2);
    chk("abort_in_busy", 512'(dut.r_state), 512'(ST_BUSY));
    reset = 1; d_req = 0;
    tick(1);
    reset = 0;
    tick(1);
    chk("abort_err_before_stray", 512'(sched_err), 512'(0));
    tick(1);
    stray_done = 1;
    tick(1);
    stray_done = 0;
    tick(2);
    chk("abort_sched_err", 512'(sched_err), 512'(1));
    chk("abort_state_idle", 512'(dut.r_state), 512'(ST_IDLE));
    chk("abort_no_d_done", 512'(n_ddone), 512'(0));
    chk("abort_no_i_done", 512'(n_idone), 512'(0));
    chk("abort_d_rdata_reset", d_rdata, '0);
    reset = 1;
    tick(1);
    reset = 0;
    tick(1);
    chk("err_cleared_by_reset", 512'(sched_err), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
